// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
//   ADDR_W / INSTR_W : PC and instruction word widths
//   PC_STEP          : fetch PC increment per issued request
//   RESET_PC         : fetch PC after reset
//   fq_entry_t       : one buffered instruction tagged with its PC
package fetch_queue_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the prefetch queue's memory-side and decode-side signals.
//   master : the fetch queue (drives imem_req/imem_addr and the head outputs)
//   slave  : the environment (instruction memory + decode control)
// Memory side : imem_req, imem_addr, imem_data, imem_valid
// Decode side : stall, redirect, redirect_pc, halt, out_valid, out_instr,
//               out_pc, count
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               imem_valid;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [CNT_W-1:0]   count;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        input  imem_data, imem_valid, stall, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        output imem_data, imem_valid, stall, redirect, redirect_pc, halt
    );

endinterface

// File: rtl/fq_ring.sv
// Ring-buffer storage for the prefetch queue.
//   clk, reset : clock, asynchronous active-low reset
//   push       : write push_entry at the tail
//   pop        : advance the head (caller guarantees non-empty)
//   flush      : empty the ring; overrides push and pop
//   count      : occupied entries
//   head       : entry at the read pointer, all-zero when empty
module fq_ring
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fq_entry_t                push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fq_entry_t                head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state flops use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // visible once count covers it, so its power-up contents never leak out.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_entry;
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_q] : '0;

    // The credit rule in the fetch logic must make these impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && !flush && count_q == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(pop && !flush && count_q == '0));

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, issues one-word requests to
// a 1-cycle-latency instruction memory and buffers tagged responses for decode.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : fetch_queue_if.master (memory request/response, decode
//                stall/redirect/halt, head entry and occupancy)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              inflight_q, inflight_d;
    logic              discard_q, discard_d;
    // Holds requests off for the first cycle after reset release so the
    // first fetch is cleanly separated from the reset edge.
    logic              started_q, started_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              issue, push, pop;
    fq_entry_t         head, push_entry;

    // Credit uses registered count/inflight only; a same-cycle pop is not
    // credited, which keeps the request path off the decode stall path.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue      = started_q && !bus.halt && !bus.redirect && (occupancy < DEPTH_X);
    // A response is only ours if a request was outstanding and not flushed.
    assign push       = bus.imem_valid && inflight_q && !discard_q && !bus.redirect;
    assign pop        = (count != '0) && !bus.stall && !bus.redirect;
    assign push_entry = '{instr: bus.imem_data, pc: tag_pc_q};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = issue;
        discard_d  = bus.redirect && inflight_q;
        started_d  = 1'b1;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            tag_pc_d   = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            started_q  <= started_d;
        end
    end

    fq_ring #(.DEPTH(DEPTH)) u_ring (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect),
        .count      (count),
        .head       (head)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign bus.count     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a constant table for the reset/steady
// state/stall sequence, hand-written redirect, halt, wrap and reset sequences,
// and a randomized run checked every cycle against a queue-based model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_err    = 0;

    // Instruction memory: answers a request seen at one edge in the next cycle.
    logic               mem_v;
    logic [INSTR_W-1:0] mem_d;

    // Reference model: buffered entries, outstanding request PCs, fetch PC.
    fq_entry_t         mq[$];
    logic [ADDR_W-1:0] outst[$];
    logic [ADDR_W-1:0] m_pc;
    bit                m_started;

    typedef struct {
        logic              st;
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              vld;
        logic [ADDR_W-1:0] pc;
        int                cnt;
    } vec_t;
    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_req();
        return m_started && !bus.halt && !bus.redirect && (mq.size() + outst.size() < DEPTH);
    endfunction

    task automatic model_clear();
        mq.delete();
        outst.delete();
        m_pc      = 16'h0000;
        m_started = 1'b0;
    endtask

    task automatic model_check();
        fq_entry_t h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        check("imem_req",  bus.imem_req,  model_req());
        check("imem_addr", bus.imem_addr, m_pc);
        check("out_valid", bus.out_valid, mq.size() != 0);
        check("out_instr", bus.out_instr, h.instr);
        check("out_pc",    bus.out_pc,    h.pc);
        check("count",     bus.count,     mq.size());
    endtask

    task automatic model_step();
        bit        rq;
        bit        pp;
        fq_entry_t e;
        rq = model_req();
        pp = (mq.size() != 0) && !bus.stall && !bus.redirect;
        if (bus.redirect) begin
            mq.delete();
            outst.delete();
            m_pc = bus.redirect_pc;
        end else begin
            if (pp) void'(mq.pop_front());
            if (bus.imem_valid && outst.size() != 0) begin
                e.pc    = outst.pop_front();
                e.instr = bus.imem_data;
                mq.push_back(e);
            end
            if (rq) begin
                outst.push_back(m_pc);
                m_pc = m_pc + 16'd2;
            end
        end
        m_started = 1'b1;
    endtask

    task automatic begin_cycle(input logic st, input logic rd, input logic [ADDR_W-1:0] rpc, input logic hl);
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt        = hl;
        bus.imem_valid  = mem_v;
        bus.imem_data   = mem_d;
        @(negedge clk);
        model_check();
    endtask

    task automatic end_cycle();
        logic rq_seen;
        rq_seen = bus.imem_req;
        model_step();
        @(posedge clk);
        #1;
        mem_v = rq_seen;
        mem_d = INSTR_W'($urandom);
    endtask

    task automatic run_cycle(input logic st, input logic rd, input logic [ADDR_W-1:0] rpc, input logic hl);
        begin_cycle(st, rd, rpc, hl);
        end_cycle();
    endtask

    task automatic init_reset();
        reset           = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.imem_valid  = 1'b0;
        bus.imem_data   = '0;
        mem_v           = 1'b0;
        mem_d           = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Stall until the model holds 'cnt' entries with one request outstanding.
    task automatic stall_until(input string name, input int cnt);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (mq.size() == cnt && outst.size() == 1) ok = 1'b1;
            else run_cycle(1'b1, 1'b0, '0, 1'b0);
        end
        check(name, ok, 1'b1);
    endtask

    // Run unstalled until out_valid appears and check the first head PC.
    task automatic wait_valid(input string name, input logic [ADDR_W-1:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            begin_cycle(1'b0, 1'b0, '0, 1'b0);
            if (bus.out_valid) begin
                seen = 1'b1;
                check(name, bus.out_pc, exp_pc);
            end
            end_cycle();
        end
        check({name, "_seen"}, seen, 1'b1);
    endtask

    initial begin
        logic [ADDR_W-1:0] held_pc;
        logic [ADDR_W-1:0] rpc;

        // Cycle-by-cycle expectation from reset release: fill, steady state,
        // a six-cycle stall up to full, then drain and refill.
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0000, 1};
        tbl[4]  = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0002, 1};
        tbl[5]  = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h0004, 1};
        tbl[6]  = '{1'b1, 1'b1, 16'h000A, 1'b1, 16'h0006, 1};
        tbl[7]  = '{1'b1, 1'b1, 16'h000C, 1'b1, 16'h0006, 2};
        tbl[8]  = '{1'b1, 1'b0, 16'h000E, 1'b1, 16'h0006, 3};
        tbl[9]  = '{1'b1, 1'b0, 16'h000E, 1'b1, 16'h0006, 4};
        tbl[10] = '{1'b1, 1'b0, 16'h000E, 1'b1, 16'h0006, 4};
        tbl[11] = '{1'b1, 1'b0, 16'h000E, 1'b1, 16'h0006, 4};
        tbl[12] = '{1'b0, 1'b0, 16'h000E, 1'b1, 16'h0006, 4};
        tbl[13] = '{1'b0, 1'b1, 16'h000E, 1'b1, 16'h0008, 3};
        tbl[14] = '{1'b0, 1'b1, 16'h0010, 1'b1, 16'h000A, 2};
        tbl[15] = '{1'b0, 1'b1, 16'h0012, 1'b1, 16'h000C, 2};
        tbl[16] = '{1'b0, 1'b1, 16'h0014, 1'b1, 16'h000E, 2};

        init_reset();
        for (int i = 0; i < 17; i++) begin
            begin_cycle(tbl[i].st, 1'b0, '0, 1'b0);
            check($sformatf("tbl%0d_req", i),   bus.imem_req,  tbl[i].req);
            check($sformatf("tbl%0d_addr", i),  bus.imem_addr, tbl[i].addr);
            check($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].vld);
            check($sformatf("tbl%0d_pc", i),    bus.out_pc,    tbl[i].pc);
            check($sformatf("tbl%0d_count", i), bus.count,     tbl[i].cnt);
            end_cycle();
        end

        // Redirect with count=3 and one fetch in flight.
        init_reset();
        repeat (6) run_cycle(1'b0, 1'b0, '0, 1'b0);
        stall_until("redir_setup", 3);
        run_cycle(1'b0, 1'b1, 16'h0040, 1'b0);
        begin_cycle(1'b0, 1'b0, '0, 1'b0);
        check("redir_count",  bus.count,     0);
        check("redir_valid",  bus.out_valid, 1'b0);
        check("redir_req",    bus.imem_req,  1'b1);
        check("redir_addr",   bus.imem_addr, 16'h0040);
        end_cycle();
        wait_valid("redir_first_pc", 16'h0040);

        // Halt with count=2 and one in flight: three entries drain, PC holds.
        init_reset();
        repeat (6) run_cycle(1'b0, 1'b0, '0, 1'b0);
        stall_until("halt_setup", 2);
        held_pc = m_pc;
        for (int i = 0; i < 5; i++) begin
            begin_cycle(1'b0, 1'b0, '0, 1'b1);
            check($sformatf("halt%0d_no_req", i), bus.imem_req, 1'b0);
            check($sformatf("halt%0d_count", i),  bus.count, (i < 3) ? 2 - (i == 0 ? 0 : i - 1) - (i == 0 ? 0 : 0) : 0);
            end_cycle();
        end
        begin_cycle(1'b0, 1'b0, '0, 1'b1);
        check("halt_drained", bus.out_valid, 1'b0);
        check("halt_pc_held", bus.imem_addr, held_pc);
        end_cycle();
        begin_cycle(1'b0, 1'b0, '0, 1'b0);
        check("halt_resume_req",  bus.imem_req,  1'b1);
        check("halt_resume_addr", bus.imem_addr, held_pc);
        end_cycle();
        wait_valid("halt_resume_pc", held_pc);

        // PC wrap from 0xFFFE to 0x0000.
        init_reset();
        repeat (3) run_cycle(1'b0, 1'b0, '0, 1'b0);
        run_cycle(1'b0, 1'b1, 16'hFFFE, 1'b0);
        begin_cycle(1'b0, 1'b0, '0, 1'b0);
        check("wrap_addr0", bus.imem_addr, 16'hFFFE);
        end_cycle();
        begin_cycle(1'b0, 1'b0, '0, 1'b0);
        check("wrap_addr1", bus.imem_addr, 16'h0000);
        end_cycle();
        wait_valid("wrap_pc0", 16'hFFFE);
        begin_cycle(1'b0, 1'b0, '0, 1'b0);
        check("wrap_pc1", bus.out_pc, 16'h0000);
        end_cycle();

        // Asynchronous reset mid-stream with count=3, then a stale response.
        init_reset();
        repeat (6) run_cycle(1'b0, 1'b0, '0, 1'b0);
        stall_until("rst_setup", 3);
        #2;
        reset = 1'b0;
        #1;
        check("rst_req",   bus.imem_req,  1'b0);
        check("rst_addr",  bus.imem_addr, 16'h0000);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_instr", bus.out_instr, 16'h0000);
        check("rst_pc",    bus.out_pc,    16'h0000);
        check("rst_count", bus.count,     0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_v = 1'b1;
        mem_d = INSTR_W'($urandom);
        run_cycle(1'b0, 1'b0, '0, 1'b0);
        begin_cycle(1'b0, 1'b0, '0, 1'b0);
        check("rst_stale_dropped", bus.count, 0);
        end_cycle();
        wait_valid("rst_restart_pc", 16'h0000);

        // Randomized traffic against the model.
        init_reset();
        for (int i = 0; i < 1500; i++) begin
            rpc = ADDR_W'($urandom) & 16'hFFFE;
            run_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rpc,
                      $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
